// File: rtl/line_mem_server.sv
// Shared 128-bit line store answering I-cache and D-cache line fills with a fixed
// latency, plus a free-running D-cache write-back port into the same array.
module line_mem_server #(
  parameter int    LATENCY   = 3,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Ic_mem_req,
  input  logic [9:0]   Ic_mem_addr,
  output logic [127:0] F_mem_inst,
  output logic         F_mem_valid,
  input  logic         Dc_mem_req,
  input  logic [9:0]   Dc_mem_addr,
  output logic [127:0] MEM_data_line,
  output logic         MEM_mem_valid,
  input  logic         Dc_wb_we,
  input  logic [9:0]   Dc_wb_addr,
  input  logic [127:0] Dc_wb_wline,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  // Handshake: a requester holds req and addr stable until its one-cycle valid
  // pulse; req is only sampled in IDLE, so level changes while busy are ignored.

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] DEPTH_L = 11'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  logic [127:0] mem [DEPTH];

  state_e       state_q, state_d;
  logic [3:0]   count_q, count_d;
  side_e        side_q, side_d;
  side_e        rr_last_q, rr_last_d;
  logic [9:0]   addr_q, addr_d;
  logic [127:0] line_q, line_d;

  logic         rd_in_range;
  logic         wb_in_range;
  logic         wb_hit;
  logic [127:0] rd_data;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign rd_in_range = {1'b0, addr_q} < DEPTH_L;
  assign wb_in_range = {1'b0, Dc_wb_addr} < DEPTH_L;
  assign rd_data     = rd_in_range ? mem[addr_q[AW-1:0]] : '0;
  // Write-first: a write landing on the load edge must be what the requester sees.
  assign wb_hit      = Dc_wb_we && wb_in_range && (Dc_wb_addr == addr_q);

  always_ff @(posedge clk) begin
    if (Dc_wb_we && wb_in_range) mem[Dc_wb_addr[AW-1:0]] <= Dc_wb_wline;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      side_q    <= SIDE_I;
      rr_last_q <= SIDE_I;
      addr_q    <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      side_q    <= side_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    side_d    = side_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    line_d    = line_q;
    unique case (state_q)
      S_IDLE: begin
        if (Ic_mem_req || Dc_mem_req) begin
          if (Ic_mem_req && Dc_mem_req) side_d = (rr_last_q == SIDE_I) ? SIDE_D : SIDE_I;
          else                          side_d = Dc_mem_req ? SIDE_D : SIDE_I;
          addr_d  = (side_d == SIDE_D) ? Dc_mem_addr : Ic_mem_addr;
          count_d = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q == 4'd0) begin
          line_d  = wb_hit ? Dc_wb_wline : rd_data;
          state_d = S_RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_RESP: begin
        rr_last_d = side_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign F_mem_valid   = (state_q == S_RESP) && (side_q == SIDE_I);
  assign MEM_mem_valid = (state_q == S_RESP) && (side_q == SIDE_D);
  assign F_mem_inst    = F_mem_valid   ? line_q : '0;
  assign MEM_data_line = MEM_mem_valid ? line_q : '0;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_line_mem_server.sv
// Bench for line_mem_server: unit 0 runs LATENCY=3/DEPTH=1024, unit 1 LATENCY=1/DEPTH=16.
module tb_line_mem_server;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req    [2];
  logic [9:0]   ic_addr   [2];
  logic [127:0] f_inst    [2];
  logic         f_valid   [2];
  logic         dc_req    [2];
  logic [9:0]   dc_addr   [2];
  logic [127:0] mem_line  [2];
  logic         mem_valid [2];
  logic         wb_we     [2];
  logic [9:0]   wb_addr   [2];
  logic [127:0] wb_wline  [2];
  logic         busy      [2];
  logic [1:0]   dbg       [2];

  logic [127:0] ref_mem [2][1024];
  int n_checks;
  int n_pass;

  always #5 clk = ~clk;

  line_mem_server #(.LATENCY(3), .DEPTH(1024)) dut0 (
    .clk(clk), .rst(rst),
    .Ic_mem_req(ic_req[0]), .Ic_mem_addr(ic_addr[0]),
    .F_mem_inst(f_inst[0]), .F_mem_valid(f_valid[0]),
    .Dc_mem_req(dc_req[0]), .Dc_mem_addr(dc_addr[0]),
    .MEM_data_line(mem_line[0]), .MEM_mem_valid(mem_valid[0]),
    .Dc_wb_we(wb_we[0]), .Dc_wb_addr(wb_addr[0]), .Dc_wb_wline(wb_wline[0]),
    .busy(busy[0]), .dbg_state_o(dbg[0])
  );

  line_mem_server #(.LATENCY(1), .DEPTH(16)) dut1 (
    .clk(clk), .rst(rst),
    .Ic_mem_req(ic_req[1]), .Ic_mem_addr(ic_addr[1]),
    .F_mem_inst(f_inst[1]), .F_mem_valid(f_valid[1]),
    .Dc_mem_req(dc_req[1]), .Dc_mem_addr(dc_addr[1]),
    .MEM_data_line(mem_line[1]), .MEM_mem_valid(mem_valid[1]),
    .Dc_wb_we(wb_we[1]), .Dc_wb_addr(wb_addr[1]), .Dc_wb_wline(wb_wline[1]),
    .busy(busy[1]), .dbg_state_o(dbg[1])
  );

  function automatic int lat_of(int u);
    return (u == 0) ? 3 : 1;
  endfunction

  function automatic int dep_of(int u);
    return (u == 0) ? 1024 : 16;
  endfunction

  // Reference: a read returns the array as it stands at the load edge, zero when out of range.
  function automatic logic [127:0] ref_read(int u, logic [9:0] a);
    if (int'(a) < dep_of(u)) return ref_mem[u][a];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int u = 0; u < 2; u++) begin
      ic_req[u] = 1'b0; ic_addr[u] = '0; dc_req[u] = 1'b0; dc_addr[u] = '0;
      wb_we[u] = 1'b0; wb_addr[u] = '0; wb_wline[u] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wb_write(input int u, input logic [9:0] a, input logic [127:0] d);
    wb_we[u] = 1'b1; wb_addr[u] = a; wb_wline[u] = d;
    tick();
    wb_we[u] = 1'b0;
    if (int'(a) < dep_of(u)) ref_mem[u][a] = d;
  endtask

  // Edge 1 after raising req is the accepting edge; lat_seen counts edges after it.
  task automatic read_line(input int u, input bit is_d, input logic [9:0] a,
                           input bit wr, input int wr_edge, input logic [9:0] wa,
                           input logic [127:0] wd,
                           output int lat_seen, output logic [127:0] data,
                           output bit other_seen);
    lat_seen = -1; data = '0; other_seen = 1'b0;
    if (is_d) begin dc_req[u] = 1'b1; dc_addr[u] = a; end
    else      begin ic_req[u] = 1'b1; ic_addr[u] = a; end
    for (int e = 1; e <= 40; e++) begin
      if (wr && e == wr_edge) begin
        wb_we[u] = 1'b1; wb_addr[u] = wa; wb_wline[u] = wd;
      end
      tick();
      wb_we[u] = 1'b0;
      if ((is_d ? f_valid[u] : mem_valid[u]) === 1'b1) other_seen = 1'b1;
      if ((is_d ? mem_valid[u] : f_valid[u]) === 1'b1) begin
        lat_seen = e - 1;
        data = is_d ? mem_line[u] : f_inst[u];
        break;
      end
    end
    dc_req[u] = 1'b0; ic_req[u] = 1'b0;
    tick();
  endtask

  task automatic preload();
    logic [127:0] d;
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < ((u == 0) ? 32 : 16); a++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        if (u == 0 && a == 5) d = 128'h00000004_00000003_00000002_00000001;
        wb_write(u, 10'(a), d);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (f_valid[u] !== 1'b0 || mem_valid[u] !== 1'b0) $display("FAIL reset_valid u%0d: got %b/%b expected 0/0", u, f_valid[u], mem_valid[u]);
      else n_pass++;
      n_checks++;
      if (f_inst[u] !== '0 || mem_line[u] !== '0) $display("FAIL reset_lines u%0d: got %h/%h expected 0", u, f_inst[u], mem_line[u]);
      else n_pass++;
      n_checks++;
      if (busy[u] !== 1'b0 || dbg[u] !== 2'd0) $display("FAIL reset_busy u%0d: got busy %b state %0d expected 0/0", u, busy[u], dbg[u]);
      else n_pass++;
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    int lat; logic [127:0] d; bit oth;
    read_line(0, 1'b0, 10'd5, 1'b0, 0, '0, '0, lat, d, oth);
    n_checks++;
    if (lat !== 3) $display("FAIL basic_latency: got %0d expected 3", lat);
    else n_pass++;
    n_checks++;
    if (d !== 128'h00000004_00000003_00000002_00000001) $display("FAIL basic_data: got %h expected %h", d, 128'h00000004_00000003_00000002_00000001);
    else n_pass++;
    n_checks++;
    if (oth !== 1'b0) $display("FAIL basic_other_valid: got %b expected 0", oth);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int ed, ei, lat, first_e, second_e; logic [127:0] dd, di, exp_d, exp_i, tmp;
    logic [9:0] ad, ai; bit d_first, oth;
    do_reset();
    first_e  = 1 + lat_of(0);
    second_e = 1 + 2 * (lat_of(0) + 1);
    for (int round = 0; round < 3; round++) begin
      d_first = (round != 2);
      if (round == 2) read_line(0, 1'b1, 10'd1, 1'b0, 0, '0, '0, lat, tmp, oth);
      ad = 10'($urandom_range(0, 31)); ai = 10'($urandom_range(0, 31));
      exp_d = ref_read(0, ad); exp_i = ref_read(0, ai);
      ed = -1; ei = -1; dd = '0; di = '0;
      dc_req[0] = 1'b1; dc_addr[0] = ad; ic_req[0] = 1'b1; ic_addr[0] = ai;
      for (int e = 1; e <= 40; e++) begin
        tick();
        if (mem_valid[0] === 1'b1) begin ed = e; dd = mem_line[0]; dc_req[0] = 1'b0; end
        if (f_valid[0] === 1'b1) begin ei = e; di = f_inst[0]; ic_req[0] = 1'b0; end
        if (ed >= 0 && ei >= 0) break;
      end
      dc_req[0] = 1'b0; ic_req[0] = 1'b0;
      tick();
      n_checks++;
      if (ed !== (d_first ? first_e : second_e)) $display("FAIL arb_d_edge r%0d: got %0d expected %0d", round, ed, d_first ? first_e : second_e);
      else n_pass++;
      n_checks++;
      if (ei !== (d_first ? second_e : first_e)) $display("FAIL arb_i_edge r%0d: got %0d expected %0d", round, ei, d_first ? second_e : first_e);
      else n_pass++;
      n_checks++;
      if (dd !== exp_d) $display("FAIL arb_d_data r%0d: got %h expected %h", round, dd, exp_d);
      else n_pass++;
      n_checks++;
      if (di !== exp_i) $display("FAIL arb_i_data r%0d: got %h expected %h", round, di, exp_i);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    int lat; logic [127:0] d, nv, exp; bit oth;
    read_line(0, 1'b1, 10'd9, 1'b1, 1 + lat_of(0), 10'd9, {4{32'hAAAAAAAA}}, lat, d, oth);
    ref_mem[0][9] = {4{32'hAAAAAAAA}};
    n_checks++;
    if (d !== {4{32'hAAAAAAAA}}) $display("FAIL coll_load_edge: got %h expected %h", d, {4{32'hAAAAAAAA}});
    else n_pass++;
    read_line(0, 1'b1, 10'd9, 1'b0, 0, '0, '0, lat, d, oth);
    n_checks++;
    if (d !== {4{32'hAAAAAAAA}}) $display("FAIL coll_reread: got %h expected %h", d, {4{32'hAAAAAAAA}});
    else n_pass++;
    nv = {$urandom, $urandom, $urandom, $urandom};
    read_line(0, 1'b0, 10'd9, 1'b1, 2, 10'd9, nv, lat, d, oth);
    ref_mem[0][9] = nv;
    n_checks++;
    if (d !== nv) $display("FAIL coll_wait_write: got %h expected %h", d, nv);
    else n_pass++;
    exp = ref_read(0, 10'd9);
    read_line(0, 1'b1, 10'd9, 1'b1, 1 + lat_of(0), 10'd10, ~nv, lat, d, oth);
    ref_mem[0][10] = ~nv;
    n_checks++;
    if (d !== exp) $display("FAIL coll_other_addr: got %h expected %h", d, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, extra; logic [127:0] d; bit oth;
    ic_req[0] = 1'b1; ic_addr[0] = 10'd7;
    tick(); tick();
    n_checks++;
    if (busy[0] !== 1'b1) $display("FAIL mid_busy_wait: got %b expected 1", busy[0]);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy[0] !== 1'b0 || dbg[0] !== 2'd0) $display("FAIL mid_reset_idle: got busy %b state %0d expected 0/0", busy[0], dbg[0]);
    else n_pass++;
    ic_req[0] = 1'b0;
    tick();
    rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (f_valid[0] === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL mid_no_valid: got %0d pulses expected 0", extra);
    else n_pass++;
    read_line(0, 1'b0, 10'd7, 1'b0, 0, '0, '0, lat, d, oth);
    n_checks++;
    if (d !== ref_read(0, 10'd7)) $display("FAIL mid_data_kept: got %h expected %h", d, ref_read(0, 10'd7));
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [127:0] d; bit oth;
    read_line(1, 1'b1, 10'd20, 1'b0, 0, '0, '0, lat, d, oth);
    n_checks++;
    if (lat !== lat_of(1)) $display("FAIL oor_latency: got %0d expected %0d", lat, lat_of(1));
    else n_pass++;
    n_checks++;
    if (d !== '0) $display("FAIL oor_zero_line: got %h expected 0", d);
    else n_pass++;
    wb_write(1, 10'd20, {$urandom, $urandom, $urandom, $urandom});
    for (int a = 0; a < 16; a++) begin
      read_line(1, 1'b0, 10'(a), 1'b0, 0, '0, '0, lat, d, oth);
      n_checks++;
      if (d !== ref_read(1, 10'(a))) $display("FAIL oor_line_%0d: got %h expected %h", a, d, ref_read(1, 10'(a)));
      else n_pass++;
    end
  endtask

  task automatic test_stream();
    int k, prev, extra;
    k = 0; prev = -1; extra = 0;
    ic_req[1] = 1'b1; ic_addr[1] = '0;
    for (int e = 1; e <= 40 && k < 4; e++) begin
      tick();
      if (f_valid[1] === 1'b1) begin
        n_checks++;
        if (f_inst[1] !== ref_read(1, 10'(k))) $display("FAIL stream_data_%0d: got %h expected %h", k, f_inst[1], ref_read(1, 10'(k)));
        else n_pass++;
        n_checks++;
        if (k == 0 && e !== 1 + lat_of(1)) $display("FAIL stream_first: got edge %0d expected %0d", e, 1 + lat_of(1));
        else if (k > 0 && e - prev !== lat_of(1) + 2) $display("FAIL stream_period_%0d: got %0d expected %0d", k, e - prev, lat_of(1) + 2);
        else n_pass++;
        prev = e; k++;
        ic_addr[1] = 10'(k);
        if (k == 4) ic_req[1] = 1'b0;
      end
    end
    ic_req[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (f_valid[1] === 1'b1) extra++;
    end
    n_checks++;
    if (k !== 4 || extra !== 0) $display("FAIL stream_count: got %0d pulses + %0d extra expected 4 + 0", k, extra);
    else n_pass++;
  endtask

  task automatic test_random();
    int u, lat, we_edge; bit is_d, wr, oth; logic [9:0] a, wa;
    logic [127:0] d, wd, exp;
    for (int it = 0; it < 30; it++) begin
      u = int'($urandom_range(0, 1));
      is_d = 1'($urandom_range(0, 1));
      a = 10'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      we_edge = int'($urandom_range(1, 1 + lat_of(u)));
      wa = ($urandom_range(0, 1) == 1) ? a : 10'($urandom_range(0, 31));
      wd = {$urandom, $urandom, $urandom, $urandom};
      read_line(u, is_d, a, wr, we_edge, wa, wd, lat, d, oth);
      if (wr && int'(wa) < dep_of(u)) ref_mem[u][wa] = wd;
      exp = ref_read(u, a);
      n_checks++;
      if (lat !== lat_of(u)) $display("FAIL rand_latency it%0d: got %0d expected %0d", it, lat, lat_of(u));
      else n_pass++;
      n_checks++;
      if (d !== exp) $display("FAIL rand_data it%0d: got %h expected %h", it, d, exp);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    preload();
    test_basic_read();
    test_arbitration();
    test_collision();
    test_reset_mid();
    test_out_of_range();
    test_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
